// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store sequencer between the LSU request port and a
// word-only, single-port data memory. Loads are extended from the addressed
// lane. Sub-word stores become a read-modify-write because the memory has no
// byte enables. Misaligned or illegal-size requests are answered with an
// error and never reach the memory.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RMW_WR = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_WIDTH-1:0] rmw_data_q, rmw_data_d;

    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            lane;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    assign word_addr = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign lane      = req_addr_i[1:0];

    assign rvalid_o = (state_q == RESP);
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    // Flag illegal sizes and accesses not aligned to their own size
    always_comb begin
        addr_err = 1'b0;
        case (req_size_i)
            2'b00:   addr_err = 1'b0;
            2'b01:   addr_err = lane[0];
            2'b10:   addr_err = (lane != 2'b00);
            default: addr_err = 1'b1;
        endcase
    end

    // Select the addressed byte or half of the memory word and extend it
    always_comb begin
        load_byte = 8'h00;
        case (lane)
            2'd0:    load_byte = mem_rdata_i[7:0];
            2'd1:    load_byte = mem_rdata_i[15:8];
            2'd2:    load_byte = mem_rdata_i[23:16];
            default: load_byte = mem_rdata_i[31:24];
        endcase
        load_half = lane[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_ext  = mem_rdata_i;
        case (req_size_i)
            2'b00: load_ext = req_unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, load_byte}
                                             : {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            2'b01: load_ext = req_unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, load_half}
                                             : {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    // Build the RMW word: current memory contents with the store lane replaced
    always_comb begin
        merged = mem_rdata_i;
        if (req_size_i == 2'b00) begin
            case (lane)
                2'd0:    merged[7:0]   = req_wdata_i[7:0];
                2'd1:    merged[15:8]  = req_wdata_i[7:0];
                2'd2:    merged[23:16] = req_wdata_i[7:0];
                default: merged[31:24] = req_wdata_i[7:0];
            endcase
        end else if (lane[1]) begin
            merged[31:16] = req_wdata_i[15:0];
        end else begin
            merged[15:0] = req_wdata_i[15:0];
        end
    end

    // Sequencer: accept in IDLE, finish sub-word stores in RMW_WR, answer in RESP
    always_comb begin
        state_d     = state_q;
        gnt_o       = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        rmw_addr_d  = rmw_addr_q;
        rmw_data_d  = rmw_data_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    gnt_o   = 1'b1;
                    state_d = RESP;
                    if (addr_err) begin
                        err_d = 1'b1;
                    end else if (req_we_i && (req_size_i == 2'b10)) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = 1'b1;
                        mem_addr_o  = word_addr;
                        mem_wdata_o = req_wdata_i;
                    end else if (req_we_i) begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = word_addr;
                        rmw_addr_d = word_addr;
                        rmw_data_d = merged;
                        state_d    = RMW_WR;
                    end else begin
                        mem_en_o   = 1'b1;
                        mem_addr_o = word_addr;
                        rdata_d    = load_ext;
                    end
                end
            end
            RMW_WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = rmw_addr_q;
                mem_wdata_o = rmw_data_q;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response data and the pending read-modify-write word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q    <= '0;
            err_q      <= 1'b0;
            rmw_addr_q <= '0;
            rmw_data_q <= '0;
        end else begin
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            rmw_addr_q <= rmw_addr_d;
            rmw_data_q <= rmw_data_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: self-checking bench for data_mem_ctrl with a word memory
// model and a byte-array reference of the load/store rules.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] tb_mem [0:255];
    logic        mem_clear;
    logic [7:0]  ref_bytes [0:1023];
    logic [31:0] held_vals [0:2];

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        int          exp_we;
    } vec_t;

    vec_t tbl[$];

    data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .err_o          (err),
        .mem_en_o       (mem_en),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the clock edge
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_en && !mem_we) ? tb_mem[mem_addr[9:2]] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian words
    task automatic refAccess(input logic [31:0] a, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] wd,
                             output logic [31:0] e_rdata, output logic e_err,
                             output int e_lat, output int e_en, output int e_we);
        int n;
        int base;
        logic [31:0] v;
        e_err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        e_rdata = '0;
        e_lat   = 1;
        e_en    = 0;
        e_we    = 0;
        if (e_err) return;
        n    = 1 << sz;
        base = int'(a[9:0]);
        if (we) begin
            for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8*i +: 8];
            e_we  = 1;
            e_en  = (n == 4) ? 1 : 2;
            e_lat = e_en;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[base + i];
            if (!uns && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            e_rdata = v;
            e_en    = 1;
        end
    endtask

    // One complete request: wait for the grant, then watch four cycles
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic we,
                                 input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                 input logic [31:0] e_rdata, input logic e_err,
                                 input int e_lat, input int e_en, input int e_we);
        int waited, lat, en_cnt, we_cnt, rv_cnt;
        logic [31:0] got_rdata;
        logic        got_err;
        @(negedge clk);
        req = 1'b1; req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
        #1;
        waited = 0;
        while (!gnt && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!gnt) begin
            req = 1'b0;
            checkOutput({tag, " grant timeout"}, 32'(gnt), 32'd1);
            return;
        end
        en_cnt = int'(mem_en);
        we_cnt = int'(mem_we);
        if (mem_en) checkOutput({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
        @(posedge clk);
        #1;
        req = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
        lat = 0; rv_cnt = 0; got_rdata = '0; got_err = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (rvalid) begin
                rv_cnt++;
                if (lat == 0) begin
                    lat = c; got_rdata = rdata; got_err = err;
                end
            end else if (lat != 0 && c == lat + 1) begin
                checkOutput({tag, " rdata cleared"}, rdata, 32'd0);
                checkOutput({tag, " err cleared"}, 32'(err), 32'd0);
            end
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
        end
        checkOutput({tag, " rdata"}, got_rdata, e_rdata);
        checkOutput({tag, " err"}, 32'(got_err), 32'(e_err));
        checkOutput({tag, " latency"}, 32'(lat), 32'(e_lat));
        checkOutput({tag, " rvalid count"}, 32'(rv_cnt), 32'd1);
        checkOutput({tag, " mem_en cycles"}, 32'(en_cnt), 32'(e_en));
        checkOutput({tag, " mem_we cycles"}, 32'(we_cnt), 32'(e_we));
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] wd, input logic [31:0] er,
                                input logic ee, input int el, input int en, input int ew);
        vec_t v;
        v.addr = a; v.we = we; v.size = sz; v.uns = uns; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_en = en; v.exp_we = ew;
        return v;
    endfunction

    task automatic setHeldOp(input int k);
        req_addr     = 32'h60;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_we       = (k % 2 == 0);
        req_wdata    = (k % 2 == 0) ? held_vals[k/2] : 32'h0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: reset, directed table, held requests, reset mid-RMW, random
    initial begin
        logic [31:0] e_r;
        logic        e_e;
        int          e_l, e_n, e_w;
        int          grants, rvs, overlap, spacing_bad, cyc, last_g, mism;
        logic        was_g;
        logic [31:0] exp_q[$];
        logic [31:0] a, wd, w;
        logic [1:0]  sz;
        logic        we, uns;

        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;
        rst_n = 1'b0; mem_clear = 1'b1;
        req = 1'b0; req_addr = '0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset err/gnt/mem_en/mem_we", {28'd0, err, gnt, mem_en, mem_we}, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);
        mem_clear = 1'b0;
        rst_n = 1'b1;

        // addr, we, size, uns, wdata, exp_rdata, exp_err, lat, en, we
        tbl.push_back(mk(32'h10, 1, 2'd2, 0, 32'h8899AABB, 32'h0, 0, 1, 1, 1));
        tbl.push_back(mk(32'h20, 1, 2'd2, 0, 32'h11223344, 32'h0, 0, 1, 1, 1));
        tbl.push_back(mk(32'h13, 0, 2'd0, 0, 32'h0, 32'hFFFFFF88, 0, 1, 1, 0));
        tbl.push_back(mk(32'h13, 0, 2'd0, 1, 32'h0, 32'h00000088, 0, 1, 1, 0));
        tbl.push_back(mk(32'h21, 1, 2'd0, 0, 32'h000000EE, 32'h0, 0, 2, 2, 1));
        tbl.push_back(mk(32'h20, 0, 2'd2, 0, 32'h0, 32'h1122EE44, 0, 1, 1, 0));
        tbl.push_back(mk(32'h20, 1, 2'd2, 0, 32'h0, 32'h0, 0, 1, 1, 1));
        tbl.push_back(mk(32'h22, 1, 2'd1, 0, 32'h1234BEEF, 32'h0, 0, 2, 2, 1));
        tbl.push_back(mk(32'h22, 0, 2'd1, 0, 32'h0, 32'hFFFFBEEF, 0, 1, 1, 0));
        tbl.push_back(mk(32'h20, 0, 2'd2, 0, 32'h0, 32'hBEEF0000, 0, 1, 1, 0));
        tbl.push_back(mk(32'h05, 0, 2'd2, 0, 32'h0, 32'h0, 1, 1, 0, 0));
        tbl.push_back(mk(32'h03, 1, 2'd1, 0, 32'hCAFE, 32'h0, 1, 1, 0, 0));
        tbl.push_back(mk(32'h00, 0, 2'd3, 0, 32'h0, 32'h0, 1, 1, 0, 0));
        tbl.push_back(mk(32'h00, 1, 2'd3, 0, 32'h55555555, 32'h0, 1, 1, 0, 0));
        tbl.push_back(mk(32'h10, 0, 2'd1, 1, 32'h0, 32'h0000AABB, 0, 1, 1, 0));
        tbl.push_back(mk(32'h11, 0, 2'd0, 0, 32'h0, 32'hFFFFFFAA, 0, 1, 1, 0));
        tbl.push_back(mk(32'h12, 0, 2'd1, 0, 32'h0, 32'hFFFF8899, 0, 1, 1, 0));
        tbl.push_back(mk(32'h30, 1, 2'd0, 0, 32'hFFFFFF55, 32'h0, 0, 2, 2, 1));
        tbl.push_back(mk(32'h30, 0, 2'd2, 0, 32'h0, 32'h00000055, 0, 1, 1, 0));
        tbl.push_back(mk(32'h30, 0, 2'd0, 0, 32'h0, 32'h00000055, 0, 1, 1, 0));
        tbl.push_back(mk(32'h20, 1, 2'd1, 0, 32'h00007777, 32'h0, 0, 2, 2, 1));
        tbl.push_back(mk(32'h20, 0, 2'd2, 0, 32'h0, 32'hBEEF7777, 0, 1, 1, 0));
        tbl.push_back(mk(32'hF0000010, 0, 2'd2, 0, 32'h0, 32'h8899AABB, 0, 1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            refAccess(tbl[i].addr, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].wdata, e_r, e_e, e_l, e_n, e_w);
            applyStimulus($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].size, tbl[i].uns,
                          tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat,
                          tbl[i].exp_en, tbl[i].exp_we);
        end

        // req held high through alternating word stores and loads
        for (int i = 0; i < 3; i++) held_vals[i] = $urandom;
        grants = 0; rvs = 0; overlap = 0; spacing_bad = 0; cyc = 0; last_g = -10;
        @(posedge clk);
        #1;
        setHeldOp(0);
        req = 1'b1;
        while (grants < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt && rvalid) overlap++;
            if (rvalid) begin
                rvs++;
                if (exp_q.size() > 0) checkOutput("held rdata", rdata, exp_q.pop_front());
            end
            was_g = gnt;
            if (gnt) begin
                refAccess(req_addr, req_we, req_size, req_unsigned, req_wdata, e_r, e_e, e_l, e_n, e_w);
                exp_q.push_back(e_r);
                if (cyc - last_g < 2) spacing_bad++;
                last_g = cyc;
                grants++;
            end
            @(posedge clk);
            #1;
            if (was_g) begin
                if (grants < 6) setHeldOp(grants);
                else req = 1'b0;
            end
        end
        req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rvalid) begin
                rvs++;
                if (exp_q.size() > 0) checkOutput("held rdata", rdata, exp_q.pop_front());
            end
        end
        checkOutput("held grants", 32'(grants), 32'd6);
        checkOutput("held rvalids", 32'(rvs), 32'd6);
        checkOutput("held gnt during resp", 32'(overlap), 32'd0);
        checkOutput("held grant spacing", 32'(spacing_bad), 32'd0);

        // Reset asserted while the RMW write is pending
        refAccess(32'h40, 1'b1, 2'd2, 1'b0, 32'h5A5A5A5A, e_r, e_e, e_l, e_n, e_w);
        applyStimulus("rmw preload", 32'h40, 1'b1, 2'd2, 1'b0, 32'h5A5A5A5A, e_r, e_e, e_l, e_n, e_w);
        @(negedge clk);
        req = 1'b1; req_addr = 32'h41; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'hAA;
        #1;
        cyc = 0;
        while (!gnt && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("rmw reset grant", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("rmw write pending", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rmw reset outputs", {29'd0, rvalid, mem_en, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rvs = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rvalid) rvs++;
        end
        checkOutput("rmw reset no rvalid", 32'(rvs), 32'd0);
        checkOutput("rmw reset word", tb_mem[16], 32'h5A5A5A5A);
        @(negedge clk);
        req = 1'b1; req_addr = 32'h40; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        #1;
        checkOutput("idle after reset gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset rvalid", 32'(rvalid), 32'd1);
        checkOutput("idle after reset rdata", rdata, 32'h5A5A5A5A);

        // Random traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            a   = $urandom;
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            refAccess(a, we, sz, uns, wd, e_r, e_e, e_l, e_n, e_w);
            applyStimulus($sformatf("rand%0d", i), a, we, sz, uns, wd, e_r, e_e, e_l, e_n, e_w);
        end

        // Whole memory image against the reference bytes
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
            if (tb_mem[i] !== w) mism++;
        end
        checkOutput("memory image words differing", 32'(mism), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
